// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcode/funct
// values, ALUOp and PCSrc codes, the decoded instruction class and the ALUOp helper.
package ctrl_pkg;

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EXE  = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB   = 3'b100;
  localparam logic [2:0] S_HALT = 3'b101;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JR     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  typedef struct packed {
    logic rtype;
    logic itype_alu;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic link;
    logic jr;
    logic halt;
    logic unknown;
  } dec_t;

  function automatic logic [2:0] alu_op(input logic [5:0] op, input logic [5:0] fn);
    logic [2:0] r;
    r = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (fn)
          F_SUB:   r = ALU_SUB;
          F_AND:   r = ALU_AND;
          F_OR:    r = ALU_OR;
          F_SLT:   r = ALU_SLT;
          F_SLL:   r = ALU_SLL;
          default: r = ALU_ADD;
        endcase
      end
      OP_ORI:                    r = ALU_OR;
      OP_BEQ, OP_BNE, OP_BLTZ:   r = ALU_SUB;
      default:                   r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct to instruction-class decode.
// jal/jr are recognised only when CTRL_JUMP_LINK_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL: dec.rtype = 1'b1;
`ifdef CTRL_JUMP_LINK_EN
          F_JR:    dec.jr = 1'b1;
`endif
          default: dec.unknown = 1'b1;
        endcase
      end
      OP_ADDI, OP_ORI:         dec.itype_alu = 1'b1;
      OP_LW:                   dec.load      = 1'b1;
      OP_SW:                   dec.store     = 1'b1;
      OP_BEQ, OP_BNE, OP_BLTZ: dec.branch    = 1'b1;
      OP_J:                    dec.jump      = 1'b1;
`ifdef CTRL_JUMP_LINK_EN
      OP_JAL: begin
        dec.jump = 1'b1;
        dec.link = 1'b1;
      end
`endif
      OP_HALT:                 dec.halt      = 1'b1;
      default:                 dec.unknown   = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle MIPS-style control unit: IF/ID/EXE/MEM/WB/HALT sequencer with
// combinational control outputs. Define CTRL_JUMP_LINK_EN to enable jal/jr.
module control_fsm
  import ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       mRD,
  output logic       mWR,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       DBDataSrc,
  output logic       WrRegDSrc,
  output logic [2:0] ALUOp,
  output logic [2:0] state
);

  dec_t       dec;
  logic [2:0] state_nx;
  logic       br_taken;

  ctrl_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .dec    (dec)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= S_IF;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = S_IF;
    case (state)
      S_IF:   state_nx = S_ID;
      S_ID: begin
        if (dec.halt)                                state_nx = S_HALT;
        else if (dec.jump || dec.jr || dec.unknown)  state_nx = S_IF;
        else                                         state_nx = S_EXE;
      end
      S_EXE: begin
        if (dec.branch)                  state_nx = S_IF;
        else if (dec.load || dec.store)  state_nx = S_MEM;
        else                             state_nx = S_WB;
      end
      S_MEM:  state_nx = dec.load ? S_WB : S_IF;
      S_WB:   state_nx = S_IF;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_IF;
    endcase
  end

  assign br_taken = ((opcode == OP_BEQ)  &&  zero) ||
                    ((opcode == OP_BNE)  && !zero) ||
                    ((opcode == OP_BLTZ) &&  sign);

  // Outputs are gated by Reset so every strobe drops the instant Reset falls.
  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = PC_NEXT;
    IRWre     = 1'b0;
    InsMemRW  = 1'b1;
    mRD       = 1'b0;
    mWR       = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    DBDataSrc = 1'b0;
    WrRegDSrc = 1'b0;
    ALUOp     = ALU_ADD;
    if (Reset) begin
      IRWre = (state == S_IF);
      case (state)
        S_ID: begin
          PCWre  = dec.jump || dec.jr || dec.unknown;
          RegWre = dec.link;
        end
        S_EXE: PCWre = dec.branch;
        S_MEM: begin
          PCWre = dec.store;
          mRD   = dec.load;
          mWR   = dec.store;
        end
        S_WB: begin
          PCWre  = 1'b1;
          RegWre = dec.rtype || dec.itype_alu || dec.load;
        end
        default: ;
      endcase
      if (PCWre) begin
        if (dec.jump)                   PCSrc = PC_JUMP;
        else if (dec.jr)                PCSrc = PC_JR;
        else if (dec.branch && br_taken) PCSrc = PC_BRANCH;
      end
      if (dec.link)                                          RegDst = 2'b00;
      else if (dec.rtype)                                    RegDst = 2'b10;
      else if (dec.itype_alu || dec.load || dec.store || dec.branch) RegDst = 2'b01;
      ALUSrcA   = dec.rtype && (funct == F_SLL);
      ALUSrcB   = dec.itype_alu || dec.load || dec.store;
      ExtSel    = (opcode != OP_ORI);
      DBDataSrc = dec.load;
      WrRegDSrc = !dec.link;
      ALUOp     = alu_op(opcode, funct);
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: per-instruction expected cycle sequences from
// a behavioural model are queued by the stimulus and checked by a separate monitor.
module tb_control_fsm;

  logic       CLK, Reset, zero, sign;
  logic [5:0] opcode, funct;
  logic       PCWre, IRWre, InsMemRW, mRD, mWR, RegWre;
  logic       ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp, state;

  control_fsm dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .funct(funct), .zero(zero), .sign(sign),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .InsMemRW(InsMemRW), .mRD(mRD), .mWR(mWR),
    .RegWre(RegWre), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
    .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .ALUOp(ALUOp), .state(state)
  );

`ifdef CTRL_JUMP_LINK_EN
  localparam bit JL = 1'b1;
`else
  localparam bit JL = 1'b0;
`endif

  typedef enum int {K_R, K_ADDI, K_ORI, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR, K_HALT, K_NOP} kind_e;
  typedef struct {
    logic [20:0] v;
    logic [20:0] m;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nfail = 0;
  event ev_probe;

  logic [5:0] op_tab[10] = '{6'h00, 6'h08, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h01, 6'h02, 6'h03};
  logic [5:0] fn_tab[7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h08};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [20:0] pack(input logic [2:0] st, input logic pcw, input logic [1:0] pcs,
      input logic irw, input logic imr, input logic mrd, input logic mwr, input logic rw,
      input logic [1:0] rd, input logic asa, input logic asb, input logic ext,
      input logic dbs, input logic wrs, input logic [2:0] aop);
    return {st, pcw, pcs, irw, imr, mrd, mwr, rw, rd, asa, asb, ext, dbs, wrs, aop};
  endfunction

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00}) return K_R;
        if (fn == 6'h08) return JL ? K_JR : K_NOP;
        return K_NOP;
      end
      6'h08: return K_ADDI;
      6'h0d: return K_ORI;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h04, 6'h05, 6'h01: return K_BR;
      6'h02: return K_J;
      6'h03: return JL ? K_JAL : K_NOP;
      6'h3f: return K_HALT;
      default: return K_NOP;
    endcase
  endfunction

  // Cycles per instruction, counting from IF; HALT gets 20 held cycles after ID.
  function automatic int n_cycles(input kind_e k);
    case (k)
      K_BR: return 3;
      K_SW, K_R, K_ADDI, K_ORI: return 4;
      K_LW: return 5;
      K_HALT: return 22;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] st_at(input kind_e k, input int c);
    if (c == 0) return 3'd0;
    if (c == 1) return 3'd1;
    if (k == K_HALT) return 3'd5;
    if (c == 2) return 3'd2;
    if (c == 3) return (k == K_LW || k == K_SW) ? 3'd3 : 3'd4;
    return 3'd4;
  endfunction

  task automatic push_reset(input string tag);
    exp_t e;
    e.v = pack(3'd0, 0, 2'd0, 0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 3'd0);
    e.m = '1;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input logic s, input int c);
    exp_t e;
    kind_e k;
    int n;
    logic [2:0] st, aop;
    logic pcw, rw, taken, aop_care;
    logic [1:0] pcs, rd;
    k = classify(op, fn);
    n = n_cycles(k);
    st = st_at(k, c);
    pcw = (c == n - 1) && (k != K_HALT);
    taken = (op == 6'h04 && z) || (op == 6'h05 && !z) || (op == 6'h01 && s);
    pcs = !pcw ? 2'd0 : (k == K_J || k == K_JAL) ? 2'd3 : (k == K_JR) ? 2'd2 :
          (k == K_BR && taken) ? 2'd1 : 2'd0;
    rw = (st == 3'd4) || (k == K_JAL && c == 1);
    rd = (k == K_JAL) ? 2'd0 : (k == K_R) ? 2'd2 : 2'd1;
    aop_care = 1'b1;
    case (k)
      K_R: case (fn)
             6'h22: aop = 3'd1;  6'h24: aop = 3'd2;  6'h25: aop = 3'd3;
             6'h2a: aop = 3'd4;  6'h00: aop = 3'd5;  default: aop = 3'd0;
           endcase
      K_ADDI, K_LW, K_SW: aop = 3'd0;
      K_ORI: aop = 3'd3;
      K_BR:  aop = 3'd1;
      default: begin aop = 3'd0; aop_care = 1'b0; end
    endcase
    e.v = pack(st, pcw, pcs, c == 0, 1'b1, k == K_LW && st == 3'd3, k == K_SW && st == 3'd3, rw,
               rd, k == K_R && fn == 6'h00, k inside {K_ADDI, K_ORI, K_LW, K_SW}, k != K_ORI,
               k == K_LW, k != K_JAL, aop);
    e.m = pack(3'h7, 1, 2'h3, 1, 1, 1, 1, 1, {2{rw}}, 1, 1, 1, 1, rw, {3{aop_care}});
    e.tag = $sformatf("op%02h/fn%02h/c%0d", op, fn, c);
    exp_q.push_back(e);
  endtask

  task automatic check_one();
    exp_t e;
    logic [20:0] act;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    act = pack(state, PCWre, PCSrc, IRWre, InsMemRW, mRD, mWR, RegWre, RegDst, ALUSrcA,
               ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc, ALUOp);
    nvec++;
    if (((act ^ e.v) & e.m) != '0) begin
      nfail++;
      $display("FAIL %s: got %b want %b care %b", e.tag, act, e.v, e.m);
    end
  endtask

  initial forever begin @(negedge CLK); check_one(); end
  initial forever begin @(ev_probe); check_one(); end

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic s, input int abort_at);
    int n;
    n = n_cycles(classify(op, fn));
    for (int c = 0; c < n; c++) begin
      @(posedge CLK); #1;
      Reset = 1'b1; opcode = op; funct = fn; zero = z; sign = s;
      push_instr(op, fn, z, s, c);
      if (c == abort_at) begin
        @(negedge CLK); #2;
        Reset = 1'b0; #1;
        push_reset("abort");
        ->ev_probe;
        return;
      end
    end
  endtask

  task automatic reset_pulse(input int ncyc);
    @(posedge CLK); #1;
    Reset = 1'b0; #1;
    push_reset("rst_now");
    ->ev_probe;
    repeat (ncyc - 1) begin
      @(posedge CLK); #1;
      push_reset("rst_hold");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    int ab;
    Reset = 1'b0; opcode = '0; funct = '0; zero = 1'b0; sign = 1'b0;
    repeat (3) begin @(posedge CLK); #1; push_reset("rst_init"); end

    run_instr(6'h00, 6'h20, 0, 0, -1);          // add
    run_instr(6'h04, 6'h00, 1, 0, -1);          // beq taken
    run_instr(6'h04, 6'h00, 0, 1, -1);          // beq not taken
    run_instr(6'h01, 6'h00, 0, 1, -1);          // bltz taken
    run_instr(6'h05, 6'h00, 0, 0, -1);          // bne taken
    run_instr(6'h23, 6'h00, 0, 0, -1);          // lw
    run_instr(6'h2b, 6'h00, 0, 0, -1);          // sw
    run_instr(6'h03, 6'h00, 0, 0, -1);          // jal
    run_instr(6'h00, 6'h08, 0, 0, -1);          // jr
    run_instr(6'h00, 6'h3f, 0, 0, -1);          // unknown funct
    run_instr(6'h0d, 6'h00, 0, 0, -1);          // ori
    run_instr(6'h00, 6'h00, 0, 0, -1);          // sll
    run_instr(6'h3f, 6'h00, 0, 0, -1);          // halt, 20 held cycles
    reset_pulse(2);
    run_instr(6'h08, 6'h00, 0, 0, -1);          // addi after reset
    run_instr(6'h2b, 6'h00, 0, 0, 3);           // sw aborted in MEM
    run_instr(6'h00, 6'h2a, 0, 0, -1);          // slt

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 99) < 4) reset_pulse($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 62));
      else op = op_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 5) == 0) fn = 6'($urandom);
      else fn = fn_tab[$urandom_range(0, 6)];
      ab = ($urandom_range(0, 19) == 0) ?
           $urandom_range(0, n_cycles(classify(op, fn)) - 1) : -1;
      run_instr(op, fn, 1'($urandom), 1'($urandom), ab);
    end

    repeat (3) @(negedge CLK);
    #1;
    nvec++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port: CLK  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: Reset  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have inputs: opcode 6b (IR[31:26]); funct 6b (IR[5:0]); zero 1b (ALU result==0); sign 1b (ALU result[31]).
REQ-004 SHALL have outputs to the program counter: PCWre 1b (PC load enable); PCSrc 2b (00 PC+4, 01 branch, 10 jr, 11 jump).
REQ-005 SHALL have outputs: IRWre 1b; InsMemRW 1b (1=read); mRD 1b; mWR 1b; RegWre 1b; RegDst 2b (00 $31, 01 rt, 10 rd); ALUSrcA 1b (1=shamt); ALUSrcB 1b (1=ext imm); ExtSel 1b (1=sign, 0=zero); DBDataSrc 1b (1=memory); WrRegDSrc 1b (0=PC+4); ALUOp 3b; state 3b.

Function
REQ-006 SHALL implement states IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101; the state register is the only storage.
REQ-007 SHALL make all outputs combinational from the current state, opcode, funct, zero and sign; state updates once per CLK.
REQ-008 SHALL take these transitions:
- IF->ID always.
- ID->IF for j, jal, jr and unknown opcodes.
- ID->HALT for opcode 111111.
- ID->EXE otherwise.
REQ-009 SHALL take these transitions:
- EXE->IF for beq, bne, bltz.
- EXE->MEM for lw, sw.
- EXE->WB for R-type, addi, ori.
- MEM->WB for lw; MEM->IF for sw.
- WB->IF always.
- HALT->HALT until reset.
REQ-010 SHALL assert PCWre for exactly one cycle per instruction, in its final state: ID (j/jal/jr/unknown), EXE (branches), MEM (sw), WB (lw, R-type, addi, ori); never in HALT.
REQ-011 SHALL drive PCSrc as follows, and 00 whenever PCWre=0:
- 11 for j/jal; 10 for jr.
- 01 for beq with zero=1, bne with zero=0, bltz with sign=1.
- 00 for a not-taken branch and for unknown opcodes.
REQ-012 SHALL assert IRWre only in IF, and InsMemRW=1 in all states.
REQ-013 SHALL assert mRD only in MEM for lw, and mWR only in MEM for sw.
REQ-014 SHALL assert RegWre in WB (R-type except jr, addi, ori, lw), and in ID for jal with RegDst=00 and WrRegDSrc=0.
REQ-015 SHALL decode R-type funct: add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, jr 001000; an unknown funct is treated as a NOP (ID->IF, PCSrc=00).
REQ-016 SHALL set ALUOp as follows:
- 000 add, addi, lw, sw.
- 001 sub and all branches.
- 010 and; 011 or/ori; 100 slt; 101 sll.
REQ-017 SHALL set the datapath selects:
- ALUSrcA=1 only for sll.
- ALUSrcB=1 for addi, ori, lw, sw.
- ExtSel=0 only for ori.
- DBDataSrc=1 only for lw.
- RegDst=10 for R-type, 01 for I-type.
REQ-018 SHALL drive state with the current state encoding.

Reset
REQ-019 SHALL force state=IF asynchronously while Reset=0 and hold it there; the first fetch occurs at the first CLK edge after Reset rises.
REQ-020 SHALL hold outputs at these values while Reset=0: PCWre=0, IRWre=0, mRD=0, mWR=0, RegWre=0, PCSrc=00, InsMemRW=1, all others 0.
REQ-021 SHALL let Reset assertion mid-instruction abort it with no write strobe (mWR, RegWre, PCWre) asserted after Reset falls.

Configuration
REQ-022 SHALL support the macro CTRL_JUMP_LINK_EN: when defined, jal (000011) and jr (funct 001000) behave per REQ-008..REQ-014.
REQ-023 SHALL, when CTRL_JUMP_LINK_EN is undefined, treat jal and jr as unknown instructions (ID->IF, PCWre=1, PCSrc=00, RegWre=0).

Structure
REQ-024 SHALL place state encodings, opcode/funct constants, ALUOp codes and PCSrc codes in shared package ctrl_pkg.
REQ-025 SHALL use one sub-module, ctrl_decode: combinational opcode/funct to instruction-class decode (rtype, itype_alu, load, store, branch, jump, link, jr, halt, unknown).

Verification
REQ-026 SHALL cover: add (000000/100000) from reset -> states IF,ID,EXE,WB,IF; RegWre=1 and PCWre=1 only in WB; RegDst=10; ALUOp=000.
REQ-027 SHALL cover: beq with zero=1 -> PCSrc=01 and PCWre=1 in EXE; beq with zero=0 -> PCSrc=00 and next state IF; bltz with sign=1 -> PCSrc=01.
REQ-028 SHALL cover: lw -> mRD=1 in MEM, DBDataSrc=1 and RegWre=1 in WB (5 cycles); sw -> mWR=1 and PCWre=1 in MEM, with 4 cycles total.
REQ-029 SHALL cover: jal with CTRL_JUMP_LINK_EN -> in ID, PCSrc=11, PCWre=1, RegWre=1, RegDst=00, WrRegDSrc=0; without the macro -> PCSrc=00 and RegWre=0.
REQ-030 SHALL cover: opcode 111111 -> HALT with PCWre=0 held for 20 cycles; Reset=0 pulse -> state=IF immediately, then normal fetch.
REQ-031 SHALL cover: Reset falling during MEM of sw -> mWR drops the same cycle and state=IF.
